// File: rtl/dmi_req_arbiter.sv
// dmi_req_arbiter: shares the DM-side DMI port between two requesters
// (m0 = JTAG DTM, m1 = secondary debug channel). One transaction is in
// flight at a time, grants are round-robin, and each response is routed
// back to its issuer. A response timeout returns a synthetic op-failed
// response, and the late DM response is then drained and discarded.
// Optional feature macro: DMI_ARB_LOCK_EN adds m0_lock_i/m1_lock_i, which
// let a requester hold the port across several transactions.
module dmi_req_arbiter #(
  parameter int TimeoutCycles = 1023
) (
  input  logic        clk_i,
  input  logic        trst_n,
  input  logic        clear_i,
  input  logic [40:0] m0_req_i,
  input  logic        m0_req_valid_i,
  output logic        m0_req_ready_o,
  output logic [33:0] m0_resp_o,
  output logic        m0_resp_valid_o,
  input  logic        m0_resp_ready_i,
  input  logic [40:0] m1_req_i,
  input  logic        m1_req_valid_i,
  output logic        m1_req_ready_o,
  output logic [33:0] m1_resp_o,
  output logic        m1_resp_valid_o,
  input  logic        m1_resp_ready_i,
`ifdef DMI_ARB_LOCK_EN
  input  logic        m0_lock_i,
  input  logic        m1_lock_i,
`endif
  output logic [40:0] dmi_req_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  input  logic [33:0] dmi_resp_i,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  output logic        owner_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int CntRaw = $clog2(TimeoutCycles + 1);
  localparam int CntW = (CntRaw < 1) ? 1 : CntRaw;
  localparam bit TimeoutEn = (TimeoutCycles != 0);
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles == 0) ? 0 : (TimeoutCycles - 1));
  localparam logic [33:0] RespTimeout = {32'h0000_0000, 2'b10};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  state_e          state_r;
  state_e          state_next_s;
  logic [40:0]     req_r;
  logic [33:0]     resp_r;
  logic            owner_r;
  logic            last_grant_r;
  logic            drain_r;
  logic [CntW-1:0] cnt_r;
  logic            grant_s;
  logic            grant_valid_s;
  logic            idle_hs_s;
  logic            resp_hs_s;
  logic            timeout_fire_s;
  logic            locked_s;

  // Grant selection: locked owner only, else sole requester, else alternate
  always_comb begin
    grant_s       = 1'b0;
    grant_valid_s = 1'b0;
    if (locked_s) begin
      grant_s       = owner_r;
      grant_valid_s = owner_r ? m1_req_valid_i : m0_req_valid_i;
    end else if (m0_req_valid_i && m1_req_valid_i) begin
      grant_s       = ~last_grant_r;
      grant_valid_s = 1'b1;
    end else if (m0_req_valid_i) begin
      grant_s       = 1'b0;
      grant_valid_s = 1'b1;
    end else if (m1_req_valid_i) begin
      grant_s       = 1'b1;
      grant_valid_s = 1'b1;
    end else begin
      grant_s       = 1'b0;
      grant_valid_s = 1'b0;
    end
  end

  assign idle_hs_s = (state_r == ST_IDLE) && grant_valid_s && !clear_i;
  assign resp_hs_s = (state_r == ST_RESP) && !clear_i &&
                     (owner_r ? m1_resp_ready_i : m0_resp_ready_i);
  // A real response on the expiry cycle wins over the timeout.
  assign timeout_fire_s = (state_r == ST_WAIT) && TimeoutEn && !clear_i &&
                          !dmi_resp_valid_i && (cnt_r == CntLast);

  // State register
  always_ff @(posedge clk_i or negedge trst_n) begin
    if (!trst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; clear_i overrides every transition
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  state_next_s = idle_hs_s ? ST_REQ : ST_IDLE;
      ST_REQ:   state_next_s = dmi_req_ready_i ? ST_WAIT : ST_REQ;
      ST_WAIT: begin
        if (dmi_resp_valid_i || timeout_fire_s) begin
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_hs_s) begin
          state_next_s = drain_r ? ST_DRAIN : ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      ST_DRAIN: state_next_s = dmi_resp_valid_i ? ST_IDLE : ST_DRAIN;
      default:  state_next_s = ST_IDLE;
    endcase
    if (clear_i) begin
      state_next_s = ST_IDLE;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // Handshake outputs decoded from state; all forced low while clear_i is high
  always_comb begin
    m0_req_ready_o   = 1'b0;
    m1_req_ready_o   = 1'b0;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;
    m0_resp_valid_o  = 1'b0;
    m1_resp_valid_o  = 1'b0;
    timeout_o        = 1'b0;
    if (!clear_i) begin
      case (state_r)
        ST_IDLE: begin
          m0_req_ready_o = idle_hs_s && !grant_s;
          m1_req_ready_o = idle_hs_s && grant_s;
        end
        ST_REQ:   dmi_req_valid_o = 1'b1;
        ST_WAIT: begin
          dmi_resp_ready_o = 1'b1;
          timeout_o        = timeout_fire_s;
        end
        ST_RESP: begin
          m0_resp_valid_o = !owner_r;
          m1_resp_valid_o = owner_r;
        end
        ST_DRAIN: dmi_resp_ready_o = 1'b1;
        default:  dmi_resp_ready_o = 1'b0;
      endcase
    end else begin
      timeout_o = 1'b0;
    end
  end

  // Datapath: latch request/response, track owner, grant history, counter, drain
  always_ff @(posedge clk_i or negedge trst_n) begin
    if (!trst_n) begin
      req_r        <= 41'h0;
      resp_r       <= 34'h0;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      drain_r      <= 1'b0;
      cnt_r        <= '0;
    end else if (clear_i) begin
      drain_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (idle_hs_s) begin
            req_r        <= grant_s ? m1_req_i : m0_req_i;
            owner_r      <= grant_s;
            last_grant_r <= grant_s;
          end
        end
        ST_REQ: begin
          if (dmi_req_ready_i) begin
            cnt_r <= '0;
          end
        end
        ST_WAIT: begin
          cnt_r <= cnt_r + CntW'(1);
          if (dmi_resp_valid_i) begin
            resp_r <= dmi_resp_i;
          end else if (timeout_fire_s) begin
            resp_r  <= RespTimeout;
            drain_r <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (dmi_resp_valid_i) begin
            drain_r <= 1'b0;
          end
        end
        default: drain_r <= drain_r;
      endcase
    end
  end

`ifdef DMI_ARB_LOCK_EN
  logic locked_r;
  logic req_lock_r;
  logic lock_in_s;

  assign lock_in_s = grant_s ? m1_lock_i : m0_lock_i;
  assign locked_s  = locked_r;

  // Lock tracking: set by a locked request, released when an unlocked one completes
  always_ff @(posedge clk_i or negedge trst_n) begin
    if (!trst_n) begin
      locked_r   <= 1'b0;
      req_lock_r <= 1'b0;
    end else if (clear_i) begin
      locked_r   <= 1'b0;
      req_lock_r <= 1'b0;
    end else if (idle_hs_s) begin
      req_lock_r <= lock_in_s;
      if (lock_in_s) begin
        locked_r <= 1'b1;
      end
    end else if (resp_hs_s && !req_lock_r) begin
      locked_r <= 1'b0;
    end
  end
`else
  assign locked_s = 1'b0;
`endif

  assign dmi_req_o = req_r;
  assign m0_resp_o = resp_r;
  assign m1_resp_o = resp_r;
  assign owner_o   = owner_r;
  assign busy_o    = (state_r != ST_IDLE);

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Self-checking bench for dmi_req_arbiter (TimeoutCycles = 8). Requests and
// responses are pushed to scoreboard queues when driven and popped when the
// DUT presents them on the DM side or back to the requester.
module tb_dmi_req_arbiter;

  logic        clk = 1'b0;
  logic        trst_n = 1'b0;
  logic        clear = 1'b0;
  logic [40:0] m0_req = 41'h0;
  logic        m0_req_valid = 1'b0;
  logic        m0_req_ready_o;
  logic [33:0] m0_resp_o;
  logic        m0_resp_valid_o;
  logic        m0_resp_ready = 1'b1;
  logic [40:0] m1_req = 41'h0;
  logic        m1_req_valid = 1'b0;
  logic        m1_req_ready_o;
  logic [33:0] m1_resp_o;
  logic        m1_resp_valid_o;
  logic        m1_resp_ready = 1'b1;
`ifdef DMI_ARB_LOCK_EN
  logic        m0_lock = 1'b0;
  logic        m1_lock = 1'b0;
`endif
  logic [40:0] dmi_req_o;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready = 1'b0;
  logic [33:0] dmi_resp = 34'h0;
  logic        dmi_resp_valid = 1'b0;
  logic        dmi_resp_ready_o;
  logic        owner_o;
  logic        busy_o;
  logic        timeout_o;

  int vectors = 0;
  int miscompares = 0;

  logic [40:0] req_q[$];
  logic [34:0] resp_q[$];   // {owner, resp}

  dmi_req_arbiter #(.TimeoutCycles(8)) dut (
    .clk_i(clk), .trst_n(trst_n), .clear_i(clear),
    .m0_req_i(m0_req), .m0_req_valid_i(m0_req_valid), .m0_req_ready_o(m0_req_ready_o),
    .m0_resp_o(m0_resp_o), .m0_resp_valid_o(m0_resp_valid_o), .m0_resp_ready_i(m0_resp_ready),
    .m1_req_i(m1_req), .m1_req_valid_i(m1_req_valid), .m1_req_ready_o(m1_req_ready_o),
    .m1_resp_o(m1_resp_o), .m1_resp_valid_o(m1_resp_valid_o), .m1_resp_ready_i(m1_resp_ready),
`ifdef DMI_ARB_LOCK_EN
    .m0_lock_i(m0_lock), .m1_lock_i(m1_lock),
`endif
    .dmi_req_o(dmi_req_o), .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready),
    .dmi_resp_i(dmi_resp), .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(dmi_resp_ready_o),
    .owner_o(owner_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Raise a request, wait (bounded) for ready, push it to the request scoreboard.
  task automatic request(input bit who, input logic [40:0] req);
    int   n;
    logic rdy;
    if (who) begin m1_req = req; m1_req_valid = 1'b1; end
    else begin m0_req = req; m0_req_valid = 1'b1; end
    #1;
    n = 0;
    rdy = who ? m1_req_ready_o : m0_req_ready_o;
    while (rdy !== 1'b1 && n < 40) begin
      tick(); #1; n++;
      rdy = who ? m1_req_ready_o : m0_req_ready_o;
    end
    vectors++;
    if (rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL req_grant m%0d: ready=%b after %0d cycles, required 1", who, rdy, n);
    end else begin
      req_q.push_back(req);
    end
    tick();
    if (who) m1_req_valid = 1'b0; else m0_req_valid = 1'b0;
  endtask

  // Called one cycle after the requester handshake: check DM request, accept it.
  task automatic dm_accept();
    logic [40:0] exp_req;
    #1;
    exp_req = 41'h0;
    if (req_q.size() != 0) exp_req = req_q.pop_front();
    vectors++;
    if (dmi_req_valid_o !== 1'b1 || dmi_resp_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL dmi_req_valid: valid=%b resp_ready=%b, required 1/0", dmi_req_valid_o, dmi_resp_ready_o);
    end
    vectors++;
    if (dmi_req_o !== exp_req) begin
      miscompares++;
      $display("FAIL dmi_req_data: got %h, required %h", dmi_req_o, exp_req);
    end
    dmi_req_ready = 1'b1;
    tick();
    dmi_req_ready = 1'b0;
  endtask

  // From the first WAIT_RESP cycle: respond after lat cycles, check routing.
  task automatic dm_respond(input bit who, input int lat, input logic [33:0] resp);
    logic [34:0] exp_r;
    logic        v_own, v_oth;
    logic [33:0] d_own;
    repeat (lat) tick();
    resp_q.push_back({who, resp});
    dmi_resp = resp; dmi_resp_valid = 1'b1;
    tick();
    dmi_resp_valid = 1'b0; dmi_resp = 34'h0;
    #1;
    exp_r = 35'h0;
    if (resp_q.size() != 0) exp_r = resp_q.pop_front();
    v_own = who ? m1_resp_valid_o : m0_resp_valid_o;
    v_oth = who ? m0_resp_valid_o : m1_resp_valid_o;
    d_own = who ? m1_resp_o : m0_resp_o;
    vectors++;
    if (v_own !== 1'b1 || v_oth !== 1'b0) begin
      miscompares++;
      $display("FAIL resp_route m%0d: own_valid=%b other_valid=%b, required 1/0", who, v_own, v_oth);
    end
    vectors++;
    if (d_own !== exp_r[33:0] || owner_o !== exp_r[34]) begin
      miscompares++;
      $display("FAIL resp_data m%0d: data=%h owner=%b, required %h/%b", who, d_own, owner_o, exp_r[33:0], exp_r[34]);
    end
    tick(); #1;
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_resp: busy=%b, required 0", busy_o);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({m0_req_ready_o, m1_req_ready_o, dmi_req_valid_o, dmi_resp_ready_o,
         m0_resp_valid_o, m1_resp_valid_o, owner_o, busy_o, timeout_o} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, required 000000000",
               {m0_req_ready_o, m1_req_ready_o, dmi_req_valid_o, dmi_resp_ready_o,
                m0_resp_valid_o, m1_resp_valid_o, owner_o, busy_o, timeout_o});
    end
    vectors++;
    if (dmi_req_o !== 41'h0 || m0_resp_o !== 34'h0 || m1_resp_o !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_data: req=%h r0=%h r1=%h, required 0", dmi_req_o, m0_resp_o, m1_resp_o);
    end
    trst_n = 1'b1;
    tick(); #1;
    vectors++;
    if (busy_o !== 1'b0 || owner_o !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: busy=%b owner=%b, required 0/0", busy_o, owner_o);
    end
  endtask

  task automatic test_contention();
    int          n0, n1, wait_n;
    bit          g;
    logic [40:0] granted;
    n0 = 0; n1 = 0;
    m0_req = {7'h01, 32'h1000_0000, 2'b01};
    m1_req = {7'h02, 32'h2000_0000, 2'b10};
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      wait_n = 0;
      while (m0_req_ready_o !== 1'b1 && m1_req_ready_o !== 1'b1 && wait_n < 20) begin
        tick(); #1; wait_n++;
      end
      g = (m1_req_ready_o === 1'b1);
      vectors++;
      if ((m0_req_ready_o ^ m1_req_ready_o) !== 1'b1 || g !== k[0]) begin
        miscompares++;
        $display("FAIL rr_grant #%0d: ready0=%b ready1=%b, required grant m%0d", k, m0_req_ready_o, m1_req_ready_o, k[0]);
        break;
      end
      granted = g ? m1_req : m0_req;
      req_q.push_back(granted);
      if (g) n1++; else n0++;
      tick();
      if (g) m1_req = {7'h02, 32'h2000_0000 + 32'(k + 1), 2'b10};
      else   m0_req = {7'h01, 32'h1000_0000 + 32'(k + 1), 2'b01};
      dm_accept();
      dm_respond(g, 1 + (k % 3), {32'hB000_0000 + 32'(k), 1'b0, g});
    end
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    vectors++;
    if (n0 != 4 || n1 != 4) begin
      miscompares++;
      $display("FAIL rr_fairness: m0=%0d m1=%0d grants, required 4/4", n0, n1);
    end
  endtask

  task automatic test_single_read();
    request(1'b0, {7'h11, 32'h0000_0000, 2'b01});
    dm_accept();
    dm_respond(1'b0, 5, {32'h1234_5678, 2'b00});
  endtask

  task automatic test_timeout();
    int          fired_at;
    logic [34:0] exp_r;
    request(1'b1, {7'h22, 32'hCAFE_F00D, 2'b10});
    dm_accept();
    resp_q.push_back({1'b1, 34'h0_0000_0002});
    fired_at = -1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (timeout_o === 1'b1) begin fired_at = i; break; end
      tick();
    end
    vectors++;
    if (fired_at != 7) begin
      miscompares++;
      $display("FAIL timeout_cycle: fired on wait cycle %0d, required 7", fired_at);
    end
    tick(); #1;
    exp_r = 35'h0;
    if (resp_q.size() != 0) exp_r = resp_q.pop_front();
    vectors++;
    if (m1_resp_valid_o !== 1'b1 || m0_resp_valid_o !== 1'b0 || m1_resp_o !== exp_r[33:0] || timeout_o !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_resp: v1=%b v0=%b data=%h to=%b, required 1/0/%h/0",
               m1_resp_valid_o, m0_resp_valid_o, m1_resp_o, timeout_o, exp_r[33:0]);
    end
    tick(); #1;
    vectors++;
    if (busy_o !== 1'b1 || dmi_resp_ready_o !== 1'b1 || m1_resp_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_state: busy=%b resp_ready=%b v1=%b, required 1/1/0", busy_o, dmi_resp_ready_o, m1_resp_valid_o);
    end
    tick();
    dmi_resp = {32'hBAD0_BAD0, 2'b00}; dmi_resp_valid = 1'b1;
    tick();
    dmi_resp_valid = 1'b0; dmi_resp = 34'h0;
    #1;
    vectors++;
    if (busy_o !== 1'b0 || m0_resp_valid_o !== 1'b0 || m1_resp_valid_o !== 1'b0 || dmi_resp_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_done: busy=%b v0=%b v1=%b resp_ready=%b, required 0/0/0/0",
               busy_o, m0_resp_valid_o, m1_resp_valid_o, dmi_resp_ready_o);
    end
  endtask

  task automatic test_race();
    logic [34:0] exp_r;
    request(1'b0, {7'h05, 32'h0000_0000, 2'b01});
    dm_accept();
    repeat (7) tick();
    dmi_resp = {32'hDEAD_BEEF, 2'b00}; dmi_resp_valid = 1'b1;
    resp_q.push_back({1'b0, 32'hDEAD_BEEF, 2'b00});
    #1;
    vectors++;
    if (timeout_o !== 1'b0) begin
      miscompares++;
      $display("FAIL race_timeout: timeout=%b, required 0", timeout_o);
    end
    tick();
    dmi_resp_valid = 1'b0; dmi_resp = 34'h0;
    #1;
    exp_r = 35'h0;
    if (resp_q.size() != 0) exp_r = resp_q.pop_front();
    vectors++;
    if (m0_resp_valid_o !== 1'b1 || m0_resp_o !== exp_r[33:0]) begin
      miscompares++;
      $display("FAIL race_data: v0=%b data=%h, required 1/%h", m0_resp_valid_o, m0_resp_o, exp_r[33:0]);
    end
    tick(); #1;
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL race_no_drain: busy=%b, required 0", busy_o);
    end
  endtask

  task automatic test_abort();
    request(1'b0, {7'h10, 32'h0000_0000, 2'b01});
    dm_accept();
    tick(); tick();
    clear = 1'b1;
    #1;
    vectors++;
    if ({dmi_resp_ready_o, dmi_req_valid_o, m0_resp_valid_o, m1_resp_valid_o, timeout_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL clear_gate: got %b, required 00000",
               {dmi_resp_ready_o, dmi_req_valid_o, m0_resp_valid_o, m1_resp_valid_o, timeout_o});
    end
    tick();
    clear = 1'b0;
    #1;
    vectors++;
    if (busy_o !== 1'b0 || dmi_resp_ready_o !== 1'b0 || m0_resp_valid_o !== 1'b0 || m1_resp_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: busy=%b resp_ready=%b v0=%b v1=%b, required 0/0/0/0",
               busy_o, dmi_resp_ready_o, m0_resp_valid_o, m1_resp_valid_o);
    end
    dmi_resp = {32'h5151_5151, 2'b00}; dmi_resp_valid = 1'b1;
    #1;
    vectors++;
    if (dmi_resp_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL late_resp_ready: resp_ready=%b, required 0", dmi_resp_ready_o);
    end
    tick();
    dmi_resp_valid = 1'b0; dmi_resp = 34'h0;
    #1;
    vectors++;
    if (m0_resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL late_resp_dropped: v0=%b busy=%b, required 0/0", m0_resp_valid_o, busy_o);
    end
    m1_req = {7'h12, 32'h0000_00AA, 2'b10}; m1_req_valid = 1'b1; clear = 1'b1;
    #1;
    vectors++;
    if (m1_req_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_ready: ready1=%b, required 0", m1_req_ready_o);
    end
    clear = 1'b0;
    request(1'b1, {7'h12, 32'h0000_00AA, 2'b10});
    dm_accept();
    dm_respond(1'b1, 3, {32'h0000_0000, 2'b00});
    vectors++;
    if (resp_q.size() != 0 || req_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: req_q=%0d resp_q=%0d, required 0/0", req_q.size(), resp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    request(1'b1, {7'h33, 32'h5555_AAAA, 2'b10});
    dm_accept();
    #1;
    vectors++;
    if (owner_o !== 1'b1 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_owner: owner=%b busy=%b, required 1/1", owner_o, busy_o);
    end
    trst_n = 1'b0;
    #1;
    vectors++;
    if (busy_o !== 1'b0 || owner_o !== 1'b0 || dmi_resp_ready_o !== 1'b0 || dmi_req_o !== 41'h0) begin
      miscompares++;
      $display("FAIL mid_reset: busy=%b owner=%b resp_ready=%b req=%h, required 0/0/0/0",
               busy_o, owner_o, dmi_resp_ready_o, dmi_req_o);
    end
    trst_n = 1'b1;
    tick();
  endtask

`ifdef DMI_ARB_LOCK_EN
  task automatic test_lock();
    logic exp_rdy;
    for (int i = 0; i < 4; i++) begin
      m1_lock = (i < 3) ? 1'b1 : 1'b0;
      request(1'b1, {7'h40, 32'h7000_0000 + 32'(i), 2'b10});
      m0_req = {7'h41, 32'h0000_0F0F, 2'b10}; m0_req_valid = 1'b1;
      dm_accept();
      dm_respond(1'b1, 2, {32'h0000_0100 + 32'(i), 2'b00});
      exp_rdy = (i == 3) ? 1'b1 : 1'b0;
      vectors++;
      if (m0_req_ready_o !== exp_rdy) begin
        miscompares++;
        $display("FAIL lock_hold #%0d: ready0=%b, required %b", i, m0_req_ready_o, exp_rdy);
      end
    end
    m1_lock = 1'b0;
    request(1'b0, {7'h41, 32'h0000_0F0F, 2'b10});
    dm_accept();
    dm_respond(1'b0, 1, {32'h0000_0F0F, 2'b00});
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_timeout();
    test_race();
    test_abort();
    test_reset_mid();
`ifdef DMI_ARB_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
